// File: rtl/aes_key_schedule_engine_if.sv
// Start/key request and round-key stream between session logic and the key-schedule engine.
// master = requester/consumer side, slave = engine side.
interface aes_key_schedule_engine_if #(
    parameter int KEY_LENGTH = 128
);
    logic                  start;
    logic [KEY_LENGTH-1:0] key;
    logic                  ready;
    logic                  rk_valid;
    logic                  rk_ready;
    logic [127:0]          round_key;
    logic [3:0]            rk_index;
    logic                  done;

    modport master (
        output start, key, rk_ready,
        input  ready, rk_valid, round_key, rk_index, done
    );

    modport slave (
        input  start, key, rk_ready,
        output ready, rk_valid, round_key, rk_index, done
    );
endinterface

// File: rtl/aes_key_schedule_engine.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per cycle, round keys streamed as 128-bit words.
// Round key r is valid 4r+4 cycles after start; a pending unaccepted key freezes the whole engine.
module aes_sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the most significant byte of the table.
    assign sub_val = SBOX_TABLE[11'd2047 - {byte_val, 3'b000} -: 8];
endmodule

module aes_key_schedule_engine #(
    parameter int KEY_LENGTH  = 128,
    parameter int WORD_LENGTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    aes_key_schedule_engine_if.slave   bus
);
    localparam int NK        = KEY_LENGTH / WORD_LENGTH;
    localparam int NR        = NK + 6;
    localparam int LAST_WORD = 4 * (NR + 1) - 1;

    if (!(KEY_LENGTH == 128 || KEY_LENGTH == 192 || KEY_LENGTH == 256) || WORD_LENGTH != 32) begin : g_bad_params
        $error("aes_key_schedule_engine: KEY_LENGTH must be 128, 192 or 256 with 32-bit words");
    end

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WORD_LENGTH-1:0] window [NK];
    logic [WORD_LENGTH-1:0] coll   [3];
    logic [5:0]             word_cnt;
    logic [2:0]             phase;
    logic [7:0]             rcon;

    logic                   rk_valid_q;
    logic [127:0]           round_key_q;
    logic [3:0]             rk_index_q;

    logic [WORD_LENGTH-1:0] w_first;
    logic [WORD_LENGTH-1:0] w_last;
    logic [WORD_LENGTH-1:0] sbox_in;
    logic [WORD_LENGTH-1:0] sub_word;
    logic [WORD_LENGTH-1:0] temp;
    logic [WORD_LENGTH-1:0] new_word;
    logic                   in_key_words;
    logic                   stall;
    logic                   advance;
    logic                   accept;
    logic                   load_key;
    logic                   last_word;

    assign w_first      = window[0];
    assign w_last       = window[NK-1];
    assign in_key_words = (word_cnt < 6'(NK));
    assign stall        = rk_valid_q && !bus.rk_ready;
    assign advance      = (state == GEN) && !stall;
    assign accept       = (state == IDLE) && bus.start;
    assign load_key     = advance && (word_cnt[1:0] == 2'b11);
    assign last_word    = (word_cnt == 6'(LAST_WORD));

    // RotWord is only applied at the start of each Nk-word group.
    assign sbox_in = (phase == 3'd0) ? {w_last[23:0], w_last[31:24]} : w_last;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_val (sbox_in[8*b +: 8]),
            .sub_val  (sub_word[8*b +: 8])
        );
    end

    always_comb begin
        temp = w_last;
        if (phase == 3'd0) begin
            temp = sub_word ^ {rcon, 24'h000000};
        end else if (NK == 8 && phase == 3'd4) begin
            temp = sub_word;
        end
    end

    // While the original key is replayed, the window rotates so w[i-Nk] is back at the head at i = Nk.
    assign new_word = in_key_words ? w_first : (w_first ^ temp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus.ready = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    state_nxt = GEN;
                end
            end
            GEN: begin
                if (advance && last_word) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (rk_valid_q && bus.rk_ready) begin
                    bus.done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NK; k++) begin
                window[k] <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                coll[k] <= '0;
            end
            word_cnt <= '0;
            phase    <= '0;
            rcon     <= 8'h01;
        end else if (accept) begin
            for (int k = 0; k < NK; k++) begin
                window[k] <= bus.key[KEY_LENGTH-1-WORD_LENGTH*k -: WORD_LENGTH];
            end
            word_cnt <= '0;
            phase    <= '0;
            rcon     <= 8'h01;
        end else if (advance) begin
            for (int k = 0; k < NK - 1; k++) begin
                window[k] <= window[k+1];
            end
            window[NK-1] <= new_word;
            coll[0]      <= coll[1];
            coll[1]      <= coll[2];
            coll[2]      <= new_word;
            word_cnt     <= word_cnt + 6'd1;
            phase        <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
            if (phase == 3'd0 && !in_key_words) begin
                rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rk_valid_q  <= 1'b0;
            round_key_q <= '0;
            rk_index_q  <= '0;
        end else if (load_key) begin
            round_key_q <= {coll[0], coll[1], coll[2], new_word};
            rk_index_q  <= word_cnt[5:2];
            rk_valid_q  <= 1'b1;
        end else if (rk_valid_q && bus.rk_ready) begin
            rk_valid_q <= 1'b0;
        end
    end

    assign bus.rk_valid  = rk_valid_q;
    assign bus.round_key = round_key_q;
    assign bus.rk_index  = rk_index_q;
endmodule

// File: tb/tb_aes_key_schedule_engine.sv
// Bench for aes_key_schedule_engine: one instance per key length, checked against a FIPS-197 style model.
module tb_aes_key_schedule_engine;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes_key_schedule_engine_if #(.KEY_LENGTH(128)) if0 ();
    aes_key_schedule_engine_if #(.KEY_LENGTH(192)) if1 ();
    aes_key_schedule_engine_if #(.KEY_LENGTH(256)) if2 ();

    aes_key_schedule_engine #(.KEY_LENGTH(128)) dut128 (.clk(clk), .reset(reset), .bus(if0));
    aes_key_schedule_engine #(.KEY_LENGTH(192)) dut192 (.clk(clk), .reset(reset), .bus(if1));
    aes_key_schedule_engine #(.KEY_LENGTH(256)) dut256 (.clk(clk), .reset(reset), .bus(if2));

    logic         start_v [3];
    logic         rdy_v   [3];
    logic [255:0] key_v   [3];
    logic         vld_w   [3];
    logic         ready_w [3];
    logic         done_w  [3];
    logic [127:0] rk_w    [3];
    logic [3:0]   idx_w   [3];

    assign if0.start = start_v[0];  assign if0.key = key_v[0][255 -: 128];  assign if0.rk_ready = rdy_v[0];
    assign if1.start = start_v[1];  assign if1.key = key_v[1][255 -: 192];  assign if1.rk_ready = rdy_v[1];
    assign if2.start = start_v[2];  assign if2.key = key_v[2];              assign if2.rk_ready = rdy_v[2];
    assign vld_w[0] = if0.rk_valid; assign ready_w[0] = if0.ready; assign done_w[0] = if0.done;
    assign rk_w[0]  = if0.round_key; assign idx_w[0] = if0.rk_index;
    assign vld_w[1] = if1.rk_valid; assign ready_w[1] = if1.ready; assign done_w[1] = if1.done;
    assign rk_w[1]  = if1.round_key; assign idx_w[1] = if1.rk_index;
    assign vld_w[2] = if2.rk_valid; assign ready_w[2] = if2.ready; assign done_w[2] = if2.done;
    assign rk_w[2]  = if2.round_key; assign idx_w[2] = if2.rk_index;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    int ptr      [3];
    int done_cyc [3];
    logic         prev_stall [3];
    logic [127:0] prev_rk    [3];
    logic [3:0]   prev_idx   [3];
    logic [7:0]   sbox_t     [256];
    logic [127:0] exp_keys   [3][15];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int nr_of(input int n);
        return 10 + 2 * n;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    function automatic void build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    function automatic void expand(input int n, input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int nk = 4 + 2 * n;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nk + 6; r++) exp_keys[n][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Compare process: every valid round key, its index, hold-while-stalled and the done pulse.
    always @(negedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (reset) begin
                prev_stall[n] = 1'b0;
            end else begin
                if (prev_stall[n]) begin
                    cmp($sformatf("stall_hold_key_%0d", n), rk_w[n], prev_rk[n]);
                    cmp($sformatf("stall_hold_idx_%0d", n), 128'(idx_w[n]), 128'(prev_idx[n]));
                    cmp($sformatf("stall_hold_vld_%0d", n), 128'(vld_w[n]), 128'(1));
                end
                if (vld_w[n]) begin
                    if (ptr[n] > nr_of(n)) begin
                        cmp($sformatf("extra_key_%0d", n), 128'(ptr[n]), 128'(nr_of(n)));
                    end else begin
                        cmp($sformatf("rk_%0d_r%0d", n, ptr[n]), rk_w[n], exp_keys[n][ptr[n]]);
                        cmp($sformatf("rk_index_%0d", n), 128'(idx_w[n]), 128'(ptr[n]));
                    end
                end
                if (vld_w[n] || done_w[n])
                    cmp($sformatf("done_%0d", n), 128'(done_w[n]),
                        128'(vld_w[n] && rdy_v[n] && ptr[n] == nr_of(n)));
                if (done_w[n]) done_cyc[n] = cyc_cnt;
                prev_stall[n] = vld_w[n] && !rdy_v[n];
                prev_rk[n]    = rk_w[n];
                prev_idx[n]   = idx_w[n];
                if (vld_w[n] && rdy_v[n]) ptr[n]++;
            end
        end
    end

    // mode 0: rk_ready high; 1: 7-cycle stall at rk3 then random; 2: start/key disturbed while busy.
    task automatic run(input int n, input logic [255:0] k, input int mode);
        int t0;
        int cyc = 0;
        int stall_left = 0;
        bit bp_on = 1'b0;
        expand(n, k);
        ptr[n] = 0;
        done_cyc[n] = -1;
        cmp($sformatf("ready_before_start_%0d", n), 128'(ready_w[n]), 128'(1));
        key_v[n] = k; start_v[n] = 1'b1; rdy_v[n] = 1'b1;
        @(posedge clk); #1;
        t0 = cyc_cnt;
        start_v[n] = 1'b0;
        while (ptr[n] <= nr_of(n) && cyc < 400) begin
            if (mode == 1) begin
                if (stall_left > 0) begin
                    rdy_v[n] = 1'b0; stall_left--;
                end else if (!bp_on && vld_w[n] && idx_w[n] == 4'd3) begin
                    bp_on = 1'b1; rdy_v[n] = 1'b0; stall_left = 6;
                end else if (bp_on) begin
                    rdy_v[n] = 1'($urandom_range(0, 1));
                end
            end
            if (mode == 2 && cyc >= 8 && cyc < 11) begin
                start_v[n] = 1'b1; key_v[n] = ~k;
                cmp($sformatf("ready_busy_%0d", n), 128'(ready_w[n]), 128'(0));
            end else begin
                start_v[n] = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_v[n] = 1'b0; rdy_v[n] = 1'b1;
        cmp($sformatf("keys_emitted_%0d", n), 128'(ptr[n]), 128'(nr_of(n) + 1));
        cmp($sformatf("ready_after_done_%0d", n), 128'(ready_w[n]), 128'(1));
        if (mode == 0) cmp($sformatf("latency_%0d", n), 128'(done_cyc[n] - t0), 128'(4 * (nr_of(n) + 1)));
    endtask

    task automatic check_reset_outputs(input int n, input string tag);
        cmp($sformatf("%s_ready_%0d", tag, n), 128'(ready_w[n]), 128'(1));
        cmp($sformatf("%s_vld_%0d", tag, n), 128'(vld_w[n]), 128'(0));
        cmp($sformatf("%s_rk_%0d", tag, n), rk_w[n], 128'(0));
        cmp($sformatf("%s_idx_%0d", tag, n), 128'(idx_w[n]), 128'(0));
        cmp($sformatf("%s_done_%0d", tag, n), 128'(done_w[n]), 128'(0));
    endtask

    initial begin
        build_sbox();
        for (int n = 0; n < 3; n++) begin
            start_v[n] = 1'b0; rdy_v[n] = 1'b1; key_v[n] = '0; ptr[n] = 0; prev_stall[n] = 1'b0;
        end
        reset = 1'b1;
        #3;
        for (int n = 0; n < 3; n++) check_reset_outputs(n, "reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Pin the model against published FIPS-197 schedule words.
        expand(0, K128);
        cmp("model_aes128_rk1", exp_keys[0][1], 128'ha0fafe1788542cb123a339392a6c7605);
        cmp("model_aes128_rk10", exp_keys[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        expand(2, K256);
        cmp("model_aes256_rk1", exp_keys[2][1], 128'h1f352c073b6108d72d9810a30914dff4);
        cmp("model_aes256_rk2", exp_keys[2][2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        cmp("model_aes256_w12", 128'(exp_keys[2][3][127:96]), 128'ha8b09c1a);
        expand(1, K192);
        cmp("model_aes192_rk1_hi", 128'(exp_keys[1][1][127:32]), 128'h62f8ead2522c6b7bfe0c91f7);

        run(0, K128, 0);
        run(2, K256, 0);
        run(1, K192, 0);
        run(0, K128, 1);
        run(1, K192, 2);

        // Asynchronous reset in the middle of generation, then a clean restart.
        expand(2, K256);
        ptr[2] = 0;
        key_v[2] = K256; start_v[2] = 1'b1;
        @(posedge clk); #1;
        start_v[2] = 1'b0;
        repeat (20) @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_outputs(2, "async_reset");
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        cmp("post_reset_no_output", 128'(vld_w[2]), 128'(0));
        cmp("post_reset_ready", 128'(ready_w[2]), 128'(1));
        run(2, K256, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_key_schedule_engine.md
Name: aes_key_schedule_engine

Overview:
- Iterative AES key-schedule generator, parameterised for AES-128/192/256.
- Accepts a cipher key on a start handshake and produces one 32-bit schedule word per cycle from an Nk-word sliding window.
- Streams the Nr+1 round keys as 128-bit words over a valid/ready interface.
- Sits between the key-exchange/session logic and the AES round datapath; replaces the fixed 128-bit, one-round-per-call expansion stage.

Parameters:
- KEY_LENGTH, 128, cipher key width; legal values 128, 192, 256 (other values are an elaboration error).
- WORD_LENGTH, 32, schedule word width; fixed, not overridable in practice.
- Nk, KEY_LENGTH/WORD_LENGTH, key length in words (4/6/8), derived.
- Nr, Nk+6, round count (10/12/14), derived.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- start  input  1  request to expand key; accepted when start && ready
- key  input  KEY_LENGTH  cipher key; key[KEY_LENGTH-1 -: 32] = w0 (FIPS-197 byte order)
- ready  output  1  engine idle, can accept start
- rk_valid  output  1  round_key holds a valid round key
- rk_ready  input  1  consumer accepts round_key this cycle
- round_key  output  128  round key r; [127:96] = w[4r], [31:0] = w[4r+3]
- rk_index  output  4  round number r of round_key (0..Nr)
- done  output  1  one-cycle pulse on the cycle the last round key (r = Nr) is accepted

Behaviour:
- Reset (asynchronous, active-high) values: ready=1, rk_valid=0, round_key=0, rk_index=0, done=0. FSM=IDLE, word counter=0, Rcon=8'h01. Reset mid-expansion aborts immediately; no partial output follows.
- FSM states:
  - IDLE -> GEN on start && ready; key is latched into the Nk-word window, i=0, phase counter j=0, Rcon=01.
  - GEN -> DRAIN once word 4(Nr+1)-1 is produced.
  - DRAIN -> IDLE on the rk_valid && rk_ready handshake of the last key; done pulses that cycle.
- ready=1 only in IDLE. start outside IDLE is ignored; the key input is sampled only at acceptance.
- GEN produces one word per edge unless stalled. Stall condition: rk_valid && !rk_ready. While stalled, window, counters, Rcon and outputs are held unchanged.
- Word generation:
  - For i < Nk: word i is key word i, taken from the window.
  - For i >= Nk: temp = w[i-1].
    - If j==0: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}, then Rcon = xtime(Rcon) (0x80 -> 0x1b).
    - Else if Nk==8 && j==4: temp = SubWord(temp).
    - w[i] = w[i-Nk] ^ temp.
  - j counts i mod Nk without a divider and wraps at Nk-1.
  - Window shifts by one word per produced word.
- SubWord uses four instances of the codebase's combinational S-box. The path is window -> S-box -> XOR -> window, one cycle, with no pipelining.
- Collection and output:
  - Produced words shift into a 4-word collector.
  - When word i with i%4==3 is produced, the collector plus that word load into round_key, rk_index = i/4 and rk_valid = 1 on that same edge.
  - rk_valid drops on handshake unless a new key loads on the same edge. A new key can load on the same edge because generation continues while rk_ready=1.
- Latency with start accepted at edge E0 and no stalls: word i is produced at edge E0+1+i; round key r is valid after edge E0+4r+4; the last key is valid after E0+4(Nr+1).
  - Totals: 44 / 52 / 60 cycles for AES-128/192/256.
  - With rk_ready tied high, one round key appears every 4 cycles.
- round_key, rk_index and rk_valid are registered and hold stable while rk_valid && !rk_ready.
- done is asserted only together with the final handshake. ready rises on the following cycle, so back-to-back start is accepted one cycle after done.

Test Plan:
- AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1 -> rk0 = key, rk1 = a0fafe17 88542cb1 23a33939 2a6c7605, rk10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, rk_index 0..10. rk10 is valid 44 cycles after start; done pulses with it.
- AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> rk1 = 1f352c07 3b6108d7 2d9810a3 0914dff4, rk2 = 9ba35411 8e6925af a51a8b5f 2067fcde. The first word of rk3 is a8b09c1a, which exercises the j==4 SubWord path. 15 keys are emitted in total.
- AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> rk0 = first 4 key words; rk1 = 62f8ead2 522c6b7b fe0c91f7 …; the remaining words are checked against the reference model. 13 keys are emitted.
- Backpressure: AES-128 with rk_ready held low for 7 cycles at rk3 and randomly toggled afterwards -> round_key/rk_index are stable while stalled, no key is lost or duplicated, and the key sequence is identical to the first test.
- start asserted while busy, and key changed mid-run -> ignored, output unaffected. reset asserted asynchronously mid-GEN -> outputs clear without a clock edge, ready=1, and a fresh start produces the correct full schedule.
